// File: rtl/decode_mdw_fifo.sv
// Assembles multi-dword instructions whose dword0 matches a format pattern and
// queues each complete instruction in a small output FIFO.
module decode_mdw_fifo #(
    parameter int          INST_DWORDS = 2,
    parameter logic [31:0] MATCH_MASK  = 32'hFC00_0000,
    parameter logic [31:0] MATCH_VALUE = 32'hD800_0000,
    parameter int          OUT_DEPTH   = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [31:0]                     inst,
    input  logic                            inst_valid,
    output logic                            inst_ready,
    input  logic                            flush,
    output logic [32*INST_DWORDS-1:0]       out_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic                            busy,
    output logic [$clog2(OUT_DEPTH):0]      fifo_count
);

    localparam int IW = (INST_DWORDS > 1) ? $clog2(INST_DWORDS) : 1;
    localparam int PW = $clog2(OUT_DEPTH);
    localparam int CW = PW + 1;
    localparam int DW = 32 * INST_DWORDS;
    localparam logic [IW-1:0] LAST_IDX = IW'(INST_DWORDS - 1);

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [31:0]     part_q [INST_DWORDS];
    logic [DW-1:0]   mem_q  [OUT_DEPTH];
    logic [PW-1:0]   wr_q, rd_q;
    logic [CW-1:0]   count_q;
    logic [DW-1:0]   assembled;
    logic            accept, match, load, push, pop;

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both 1; ready never looks at valid, and data is held while valid && !ready.
    assign inst_ready = (count_q != CW'(OUT_DEPTH));
    assign out_valid  = (count_q != '0);
    assign out_data   = mem_q[rd_q];
    assign fifo_count = count_q;
    assign busy       = (state_q == COLLECT);

    assign accept = inst_valid && inst_ready;
    assign match  = ((inst & MATCH_MASK) == MATCH_VALUE);
    assign pop    = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        load    = 1'b0;
        push    = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept && match) begin
                    load    = 1'b1;
                    idx_d   = IW'(1);
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                if (accept) begin
                    load = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        push    = 1'b1;
                        idx_d   = '0;
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // The final dword bypasses partial storage and lands in the FIFO directly.
    always_comb begin
        assembled = '0;
        for (int k = 0; k < INST_DWORDS - 1; k++) begin
            assembled[32*k +: 32] = part_q[k];
        end
        assembled[DW-1 -: 32] = inst;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else if (flush) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < INST_DWORDS; k++) begin
                part_q[k] <= '0;
            end
        end else if (load && !push && !flush) begin
            part_q[idx_q] <= inst;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < OUT_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else if (flush) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                mem_q[wr_q] <= assembled;
                wr_q        <= wr_q + PW'(1);
            end
            if (pop) begin
                rd_q <= rd_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_decode_mdw_fifo.sv
// Bench for decode_mdw_fifo: queue-based model checked every cycle on the
// default configuration, plus directed literal checks on a 4-dword instance.
module tb_decode_mdw_fifo;

    localparam int          N     = 2;
    localparam int          DEPTH = 4;
    localparam logic [31:0] MASK  = 32'hFC00_0000;
    localparam logic [31:0] VAL   = 32'hD800_0000;

    logic        clk;
    logic        reset, b_reset;
    logic [31:0] inst, b_inst;
    logic        inst_valid, b_inst_valid;
    logic        inst_ready, b_inst_ready;
    logic        flush, b_flush;
    logic [63:0] out_data;
    logic [127:0] b_out_data;
    logic        out_valid, b_out_valid;
    logic        out_ready, b_out_ready;
    logic        busy, b_busy;
    logic [2:0]  fifo_count, b_fifo_count;

    int n_cmp = 0;
    int n_err = 0;

    decode_mdw_fifo dut_a (
        .clk(clk), .reset(reset), .inst(inst), .inst_valid(inst_valid),
        .inst_ready(inst_ready), .flush(flush), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
        .fifo_count(fifo_count)
    );

    decode_mdw_fifo #(.INST_DWORDS(4)) dut_b (
        .clk(clk), .reset(b_reset), .inst(b_inst), .inst_valid(b_inst_valid),
        .inst_ready(b_inst_ready), .flush(b_flush), .out_data(b_out_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .busy(b_busy),
        .fifo_count(b_fifo_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: partial dwords and completed instructions as plain queues.
    logic [31:0] parts[$];
    logic [63:0] exp_q[$];
    logic [63:0] m_word;
    bit          m_acc, m_pop;

    always @(posedge clk or posedge reset) begin
        if (reset || flush) begin
            parts.delete();
            exp_q.delete();
        end else begin
            m_acc = inst_valid && (exp_q.size() < DEPTH);
            m_pop = out_ready && (exp_q.size() > 0);
            if (m_pop) void'(exp_q.pop_front());
            if (m_acc) begin
                if (parts.size() == 0) begin
                    if ((inst & MASK) == VAL) parts.push_back(inst);
                end else begin
                    parts.push_back(inst);
                    if (parts.size() == N) begin
                        m_word = '0;
                        for (int k = 0; k < N; k++) m_word[32*k +: 32] = parts[k];
                        exp_q.push_back(m_word);
                        parts.delete();
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("fifo_count", 128'(fifo_count), 128'(exp_q.size()));
        chk("out_valid", 128'(out_valid), 128'(exp_q.size() != 0));
        chk("inst_ready", 128'(inst_ready), 128'(exp_q.size() != DEPTH));
        chk("busy", 128'(busy), 128'(parts.size() != 0));
        if (exp_q.size() != 0) chk("out_data", 128'(out_data), 128'(exp_q[0]));
        else if (reset) chk("out_data_rst", 128'(out_data), 128'(0));
    end

    task automatic cyc(input logic v, input logic [31:0] d, input logic r, input logic f);
        inst_valid = v;
        inst       = d;
        out_ready  = r;
        flush      = f;
        @(posedge clk);
        #1;
    endtask

    task automatic cyc_b(input logic v, input logic [31:0] d);
        b_inst_valid = v;
        b_inst       = d;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] instr(input int j);
        return {32'(j) + 32'h100, VAL | 32'(j)};
    endfunction

    task automatic push_instr(input int j, input logic r_last);
        cyc(1'b1, VAL | 32'(j), 1'b0, 1'b0);
        cyc(1'b1, 32'(j) + 32'h100, r_last, 1'b0);
    endtask

    initial begin
        reset = 1'b1; b_reset = 1'b1;
        inst = '0; inst_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        b_inst = '0; b_inst_valid = 1'b0; b_flush = 1'b0; b_out_ready = 1'b0;
        #1;
        chk("rst_inst_ready", 128'(inst_ready), 128'(1));
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_count", 128'(fifo_count), 128'(0));
        chk("rst_out_data", 128'(out_data), 128'(0));
        @(posedge clk);
        #1;
        reset = 1'b0; b_reset = 1'b0;

        // Basic two-dword instruction with consumer always ready.
        cyc(1'b1, 32'hD812_3456, 1'b1, 1'b0);
        chk("basic_busy", 128'(busy), 128'(1));
        cyc(1'b1, 32'h0A0B_0C0D, 1'b1, 1'b0);
        chk("basic_valid", 128'(out_valid), 128'(1));
        chk("basic_data", 128'(out_data), 128'(64'h0A0B_0C0D_D812_3456));
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        chk("basic_popped", 128'(fifo_count), 128'(0));

        // Non-matching dword0 is ignored.
        cyc(1'b1, 32'h1234_5678, 1'b0, 1'b0);
        chk("nomatch_busy", 128'(busy), 128'(0));
        chk("nomatch_valid", 128'(out_valid), 128'(0));
        cyc(1'b1, 32'hD800_0001, 1'b0, 1'b0);
        chk("restart_busy", 128'(busy), 128'(1));
        cyc(1'b1, 32'h0000_0002, 1'b0, 1'b0);
        chk("restart_data", 128'(out_data), 128'(64'h0000_0002_D800_0001));
        cyc(1'b0, 32'h0, 1'b1, 1'b0);

        // Fill to full, confirm backpressure, drain in order.
        for (int i = 0; i < 4; i++) push_instr(i, 1'b0);
        chk("full_count", 128'(fifo_count), 128'(4));
        chk("full_ready", 128'(inst_ready), 128'(0));
        cyc(1'b1, 32'hD8AA_AAAA, 1'b0, 1'b0);
        chk("full_no_accept", 128'(busy), 128'(0));
        for (int i = 0; i < 4; i++) begin
            chk("drain_data", 128'(out_data), 128'(instr(i)));
            cyc(1'b0, 32'h0, 1'b1, 1'b0);
            chk("drain_count", 128'(fifo_count), 128'(3 - i));
            if (i == 0) chk("drain_ready", 128'(inst_ready), 128'(1));
        end

        // Simultaneous push and pop, then repeated to wrap pointers.
        push_instr(0, 1'b0);
        push_instr(1, 1'b0);
        push_instr(2, 1'b1);
        chk("pp_count", 128'(fifo_count), 128'(2));
        chk("pp_head", 128'(out_data), 128'(instr(1)));
        for (int j = 3; j < 13; j++) push_instr(j, 1'b1);
        chk("wrap_count", 128'(fifo_count), 128'(2));
        chk("wrap_head", 128'(out_data), 128'(instr(11)));
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        chk("wrap_tail", 128'(out_data), 128'(instr(12)));
        cyc(1'b0, 32'h0, 1'b1, 1'b0);

        // Flush mid-collection, with 3 entries, and together with an accept.
        cyc(1'b1, 32'hD800_0077, 1'b0, 1'b0);
        chk("pre_flush_busy", 128'(busy), 128'(1));
        cyc(1'b0, 32'h0, 1'b0, 1'b1);
        chk("flush_busy", 128'(busy), 128'(0));
        for (int j = 20; j < 23; j++) push_instr(j, 1'b0);
        chk("pre_flush_count", 128'(fifo_count), 128'(3));
        cyc(1'b0, 32'h0, 1'b0, 1'b1);
        chk("flush_count", 128'(fifo_count), 128'(0));
        chk("flush_valid", 128'(out_valid), 128'(0));
        cyc(1'b1, 32'hD8FF_FFFF, 1'b0, 1'b0);
        cyc(1'b1, 32'h0000_0001, 1'b0, 1'b0);
        chk("post_flush_data", 128'(out_data), 128'(64'h0000_0001_D8FF_FFFF));
        cyc(1'b1, 32'hD812_3456, 1'b1, 1'b1);
        chk("flush_acc_count", 128'(fifo_count), 128'(0));
        chk("flush_acc_busy", 128'(busy), 128'(0));
        cyc(1'b0, 32'h0, 1'b0, 1'b1);
        chk("flush_idle_ready", 128'(inst_ready), 128'(1));

        // Four-dword instance: asynchronous reset mid-collection.
        cyc_b(1'b1, 32'hD800_0011);
        cyc_b(1'b1, 32'h2222_2222);
        chk("b_busy", 128'(b_busy), 128'(1));
        b_reset = 1'b1;
        #1;
        chk("b_async_busy", 128'(b_busy), 128'(0));
        chk("b_async_count", 128'(b_fifo_count), 128'(0));
        chk("b_async_valid", 128'(b_out_valid), 128'(0));
        chk("b_async_ready", 128'(b_inst_ready), 128'(1));
        chk("b_async_data", b_out_data, 128'(0));
        @(posedge clk);
        #1;
        b_reset = 1'b0;
        cyc_b(1'b1, 32'h3333_3333);
        chk("b_nomatch", 128'(b_busy), 128'(0));
        cyc_b(1'b1, 32'hD800_0001);
        cyc_b(1'b1, 32'h0000_0002);
        cyc_b(1'b1, 32'h0000_0003);
        chk("b_collect_valid", 128'(b_out_valid), 128'(0));
        cyc_b(1'b1, 32'h0000_0004);
        b_inst_valid = 1'b0;
        chk("b_valid", 128'(b_out_valid), 128'(1));
        chk("b_data", b_out_data, 128'h0000_0004_0000_0003_0000_0002_D800_0001);
        chk("b_busy_done", 128'(b_busy), 128'(0));

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
